// File: rtl/dd_dequeue_prop_mq.sv
// Multi-flow dequeue propagator: per-flow occupancy and back-pressure hysteresis, one dequeue plus
// one enqueue per cycle. Optional statistics outputs are enabled by DD_DEQ_PROP_MQ_STATS_EN.
module dd_dequeue_prop_mq #(
  parameter int unsigned NUM_FLOWS    = 16,
  parameter int unsigned FLOW_ID_W    = 4,
  parameter int unsigned QSIZE_W      = 8,
  parameter int unsigned START_THRESH = 4,
  parameter int unsigned STOP_THRESH  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 deq_valid,
  input  logic [FLOW_ID_W-1:0] deq_flow,
  input  logic                 enq_valid,
  input  logic [FLOW_ID_W-1:0] enq_flow,
  output logic                 out_valid,
  output logic [FLOW_ID_W-1:0] out_flow,
  output logic [QSIZE_W-1:0]   pkt_queue_size_out,
  output logic                 back_pressure_out,
  output logic                 activated_by_dp,
  output logic                 underflow_err,
  output logic                 overflow_err
`ifdef DD_DEQ_PROP_MQ_STATS_EN
  ,
  output logic [31:0]          activations_cnt,
  output logic [QSIZE_W-1:0]   max_qsize
`endif
);

  localparam int unsigned SW = QSIZE_W + 1;
  localparam logic [SW-1:0] SizeMax = {1'b0, {QSIZE_W{1'b1}}};
  localparam logic [SW-1:0] Start   = SW'(START_THRESH);
  localparam logic [SW-1:0] Stop    = SW'(STOP_THRESH);

  logic [QSIZE_W-1:0]   size_q [NUM_FLOWS];
  logic [QSIZE_W-1:0]   size_d [NUM_FLOWS];
  logic [NUM_FLOWS-1:0] bp_q, bp_d;

  logic          same, under, over, act;
  logic [SW-1:0] deq_cur, enq_cur, deq_new, enq_new;
  logic          deq_bp_new, enq_bp_new;

  always_comb begin
    // Dequeue and enqueue on the same flow cancel out: no size change, no errors.
    same    = deq_valid && enq_valid && (deq_flow == enq_flow);
    deq_cur = {1'b0, size_q[deq_flow]};
    enq_cur = {1'b0, size_q[enq_flow]};
    under   = deq_valid && !same && (deq_cur == '0);
    over    = enq_valid && !same && (enq_cur == SizeMax);

    if (same || under) deq_new = deq_cur;
    else               deq_new = deq_cur - SW'(1);
    enq_new = over ? enq_cur : enq_cur + SW'(1);

    act        = 1'b0;
    deq_bp_new = bp_q[deq_flow];
    if (bp_q[deq_flow] && (deq_new < Start)) begin
      deq_bp_new = 1'b0;
      act        = deq_valid;
    end else if (!bp_q[deq_flow] && (deq_new >= Stop)) begin
      deq_bp_new = 1'b1;
    end
    enq_bp_new = bp_q[enq_flow] || (enq_new >= Stop);

    size_d = size_q;
    bp_d   = bp_q;
    if (enq_valid && !same) begin
      size_d[enq_flow] = enq_new[QSIZE_W-1:0];
      bp_d[enq_flow]   = enq_bp_new;
    end
    if (deq_valid) begin
      size_d[deq_flow] = deq_new[QSIZE_W-1:0];
      bp_d[deq_flow]   = deq_bp_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_FLOWS; i++) size_q[i] <= '0;
      bp_q               <= '0;
      out_valid          <= 1'b0;
      out_flow           <= '0;
      pkt_queue_size_out <= '0;
      back_pressure_out  <= 1'b0;
      activated_by_dp    <= 1'b0;
      underflow_err      <= 1'b0;
      overflow_err       <= 1'b0;
    end else begin
      size_q          <= size_d;
      bp_q            <= bp_d;
      out_valid       <= deq_valid;
      activated_by_dp <= act;
      underflow_err   <= under;
      overflow_err    <= over;
      if (deq_valid) begin
        out_flow           <= deq_flow;
        pkt_queue_size_out <= deq_new[QSIZE_W-1:0];
        back_pressure_out  <= deq_bp_new;
      end
    end
  end

`ifdef DD_DEQ_PROP_MQ_STATS_EN
  logic [SW-1:0] max_d;

  always_comb begin
    max_d = {1'b0, max_qsize};
    if (deq_valid && (deq_new > max_d))            max_d = deq_new;
    if (enq_valid && !same && (enq_new > max_d))   max_d = enq_new;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      activations_cnt <= '0;
      max_qsize       <= '0;
    end else begin
      if (act) activations_cnt <= activations_cnt + 32'd1;
      max_qsize <= max_d[QSIZE_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_dd_dequeue_prop_mq.sv
// Directed plus randomized bench for dd_dequeue_prop_mq against an arithmetic per-flow model.
module tb_dd_dequeue_prop_mq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       deq_valid = 1'b0;
  logic [3:0] deq_flow = '0;
  logic       enq_valid = 1'b0;
  logic [3:0] enq_flow = '0;
  logic       out_valid;
  logic [3:0] out_flow;
  logic [7:0] pkt_queue_size_out;
  logic       back_pressure_out, activated_by_dp, underflow_err, overflow_err;
`ifdef DD_DEQ_PROP_MQ_STATS_EN
  logic [31:0] activations_cnt;
  logic [7:0]  max_qsize;
`endif

  dd_dequeue_prop_mq dut (
    .clk                (clk),
    .rst                (rst),
    .deq_valid          (deq_valid),
    .deq_flow           (deq_flow),
    .enq_valid          (enq_valid),
    .enq_flow           (enq_flow),
    .out_valid          (out_valid),
    .out_flow           (out_flow),
    .pkt_queue_size_out (pkt_queue_size_out),
    .back_pressure_out  (back_pressure_out),
    .activated_by_dp    (activated_by_dp),
    .underflow_err      (underflow_err),
    .overflow_err       (overflow_err)
`ifdef DD_DEQ_PROP_MQ_STATS_EN
    ,
    .activations_cnt    (activations_cnt),
    .max_qsize          (max_qsize)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain integer occupancies and flags per flow.
  int msize [16];
  bit mbp [16];
  int e_flow, e_size, e_max;
  bit e_valid, e_bp, e_act, e_uf, e_of;
  longint e_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
    check({tag, ".out_flow"}, 32'(out_flow), 32'(e_flow));
    check({tag, ".size"}, 32'(pkt_queue_size_out), 32'(e_size));
    check({tag, ".bp"}, 32'(back_pressure_out), 32'(e_bp));
    check({tag, ".act"}, 32'(activated_by_dp), 32'(e_act));
    check({tag, ".underflow"}, 32'(underflow_err), 32'(e_uf));
    check({tag, ".overflow"}, 32'(overflow_err), 32'(e_of));
`ifdef DD_DEQ_PROP_MQ_STATS_EN
    check({tag, ".act_cnt"}, activations_cnt, 32'(e_cnt));
    check({tag, ".max_qsize"}, 32'(max_qsize), 32'(e_max));
`endif
  endtask

  task automatic model_reset();
    for (int f = 0; f < 16; f++) begin
      msize[f] = 0;
      mbp[f]   = 1'b0;
    end
    e_valid = 0; e_flow = 0; e_size = 0; e_bp = 0;
    e_act = 0; e_uf = 0; e_of = 0; e_cnt = 0; e_max = 0;
  endtask

  task automatic step(input string tag, input bit dv, input int df, input bit ev, input int ef);
    @(negedge clk);
    deq_valid = dv;
    deq_flow  = 4'(df);
    enq_valid = ev;
    enq_flow  = 4'(ef);
    e_act = 0; e_uf = 0; e_of = 0;
    for (int f = 0; f < 16; f++) begin
      bit d, e;
      int n;
      d = dv && (df == f);
      e = ev && (ef == f);
      if (d || e) begin
        n = msize[f] + (e ? 1 : 0) - (d ? 1 : 0);
        if (n < 0)   begin n = 0;   e_uf = 1; end
        if (n > 255) begin n = 255; e_of = 1; end
        msize[f] = n;
        if (mbp[f] && d && n < 4) begin
          mbp[f] = 0;
          e_act  = 1;
          e_cnt  = (e_cnt + 1) % 64'h1_0000_0000;
        end else if (!mbp[f] && n >= 12) begin
          mbp[f] = 1;
        end
        if (n > e_max) e_max = n;
      end
    end
    e_valid = dv;
    if (dv) begin
      e_flow = df;
      e_size = msize[df];
      e_bp   = mbp[df];
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    step("deq_empty3", 1, 3, 0, 0);

    for (int i = 0; i < 12; i++) step("enq5", 0, 0, 1, 5);
    for (int i = 0; i < 9; i++) step("deq5", 1, 5, 0, 0);
    step("idle", 0, 0, 0, 0);

    for (int i = 0; i < 12; i++) step("enq2", 0, 0, 1, 2);
    for (int i = 0; i < 8; i++) step("deq2", 1, 2, 0, 0);
    step("same2", 1, 2, 1, 2);
    step("deq2_act", 1, 2, 0, 0);

    for (int i = 0; i < 6; i++) begin
      step("fill1", 0, 0, 1, 1);
      step("fill7", 0, 0, 1, 7);
    end
    step("enq1_deq7", 1, 7, 1, 1);
    step("deq7a", 1, 7, 0, 0);
    step("deq7b", 1, 7, 0, 0);
    step("deq1", 1, 1, 0, 0);

    for (int i = 0; i < 256; i++) step("sat0", 0, 0, 1, 0);
    step("deq0", 1, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(8, 11)),
           1'($urandom_range(0, 2) != 0), int'($urandom_range(8, 11)));
    end

    // Drive flow 9 to size 10 with back-pressure set, then reset mid-stream.
    for (int i = 0; i < 20; i++) step("drain9", 1, 9, 0, 0);
    for (int i = 0; i < 12; i++) step("enq9", 0, 0, 1, 9);
    step("deq9a", 1, 9, 0, 0);
    step("deq9b", 1, 9, 0, 0);
    @(negedge clk);
    deq_valid = 1'b1;
    deq_flow  = 4'd9;
    enq_valid = 1'b1;
    enq_flow  = 4'd9;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_held");
    @(negedge clk);
    deq_valid = 1'b0;
    enq_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("rst_release");
    step("deq9_after_rst", 1, 9, 0, 0);
    step("idle_end", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dd_dequeue_prop_mq.md
Name: dd_dequeue_prop_mq

Overview:
- Multi-flow successor to the single-queue dequeue propagator in the dd_engine event processors.
- Holds a per-flow packet-queue occupancy table and a per-flow back-pressure flag with start/stop hysteresis.
- Accepts one dequeue event and one enqueue event per cycle, each for any flow.
- Emits a registered result for the dequeued flow, including an activated_by_dp pulse when back-pressure releases.

Parameters:
- NUM_FLOWS, 16, number of flows tracked (power of two, >=2).
- FLOW_ID_W, 4, flow index width (clogb2(NUM_FLOWS)).
- QSIZE_W, 8, per-flow occupancy counter width.
- START_THRESH, 4, back-pressure releases when new size < START_THRESH.
- STOP_THRESH, 12, back-pressure asserts when new size >= STOP_THRESH; must be >= START_THRESH.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- deq_valid  in  1  dequeue event
- deq_flow  in  FLOW_ID_W  flow dequeued
- enq_valid  in  1  enqueue event
- enq_flow  in  FLOW_ID_W  flow enqueued
- out_valid  out  1  result valid (one per accepted dequeue)
- out_flow  out  FLOW_ID_W  flow of result
- pkt_queue_size_out  out  QSIZE_W  post-update size of out_flow
- back_pressure_out  out  1  post-update back-pressure flag of out_flow
- activated_by_dp  out  1  pulse: this dequeue cleared back-pressure
- underflow_err  out  1  pulse: dequeue hit an empty queue
- overflow_err  out  1  pulse: enqueue hit a full queue (size = 2^QSIZE_W-1)

Behaviour:
- Reset (async, rst=1):
  - All table sizes = 0, all back-pressure flags = 0.
  - All outputs = 0.
  - Events present during reset are discarded; no output follows reset release for them.
- State: size[NUM_FLOWS] and bp[NUM_FLOWS] registers.
  - Read combinationally; written at the clk edge.
  - The next event sees the update with no hazard window.
- Per-cycle update, with d = deq_valid && deq_flow==f and e = enq_valid && enq_flow==f:
  - d only: size-1; if size==0, stay 0 and pulse underflow_err.
  - e only: size+1; if size==max, stay max and pulse overflow_err.
  - d and e on the same flow: size unchanged, no errors, net delta 0.
  - Width rule: all arithmetic at QSIZE_W+1 bits, then saturated; no wrap-around.
- Back-pressure hysteresis, evaluated on the new size only for flows touched this cycle:
  - If bp==1 and d and new<START_THRESH: bp<=0 and activated_by_dp=1 (only when d is set, i.e. the flow was dequeued this cycle).
  - Else if bp==0 and new>=STOP_THRESH: bp<=1. Can only occur via enqueue.
  - Otherwise bp holds.
  - Untouched flows are never modified.
- Outputs:
  - Latency 1 cycle: the cycle after deq_valid, out_valid=1 with out_flow, and the new size/bp of that flow.
  - The new values include the effect of a same-cycle enqueue to the same flow.
  - With no dequeue, out_valid=0; other result outputs hold their last value.
  - Pulses (activated_by_dp, underflow_err) are 0.
- overflow_err is registered and pulses one cycle after the offending enqueue, independent of out_valid.
- No ready signal: one dequeue plus one enqueue per cycle is always accepted.

Optional Feature:
- Macro DD_DEQ_PROP_MQ_STATS_EN.
- When defined:
  - Adds output activations_cnt (32 bits): total activated_by_dp pulses, reset to 0, wraps at 2^32.
  - Adds output max_qsize (QSIZE_W): high-water mark over all flows, updated from new sizes, reset to 0.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset, then a dequeue on flow 3 -> next cycle out_valid=1, out_flow=3, size=0, underflow_err=1, bp=0.
- 12 enqueues to flow 5 -> size 12, bp[5]=1 after the 12th. 8 dequeues from flow 5 -> sizes 11..4, bp stays 1, activated_by_dp=0. 9th dequeue -> size 3, bp=0, activated_by_dp=1 for exactly one cycle.
- Flow 2 at size 4 with bp=1: same-cycle enqueue and dequeue on flow 2 -> size 4, bp stays 1, no activation. Dequeue-only next -> size 3, activation pulse.
- Enqueue flow 1 and dequeue flow 7 in the same cycle, both at size 6 -> flow 1=7, flow 7=5, out_flow=7, size 5. Back-to-back dequeues of flow 7 -> 5, 4, 3 on consecutive cycles with no hazard.
- Saturation: 255 enqueues to flow 0 -> size 255; 256th -> overflow_err pulse, size stays 255.
- Assert rst mid-stream with flow 9 at size 10 and bp=1 -> outputs 0 immediately. After release, a dequeue of flow 9 reports size 0 and underflow_err. With DD_DEQ_PROP_MQ_STATS_EN, the counters read 0 after reset.
